// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies with a shift-add loop and divides with a restoring loop, one
// bit per cycle on operand magnitudes; signs are fixed up on the final edge.
// While an op is in flight stall_o holds the front of the pipeline.
module ex_muldiv_unit #(
   parameter int DATA_W     = 32,
   parameter bit EARLY_DIV0 = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [2:0]        func3_i,
   input  logic [DATA_W-1:0] rs1_i,
   input  logic [DATA_W-1:0] rs2_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
   output logic              stall_o
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Two's-complement negate when neg is set, single word.
   function automatic logic [DATA_W-1:0] f_cond_neg(input logic [DATA_W-1:0] v, input logic neg);
      if (neg) return ~v + DATA_W'(1);
      else     return v;
   endfunction

   // Two's-complement negate when neg is set, double word (full product).
   function automatic logic [2*DATA_W-1:0] f_cond_neg2(input logic [2*DATA_W-1:0] v, input logic neg);
      if (neg) return ~v + (2*DATA_W)'(1);
      else     return v;
   endfunction

   state_t              r_state;
   logic [2:0]          r_func3;
   logic [2*DATA_W-1:0] r_acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
   logic [DATA_W-1:0]   r_opnd;     // mul: multiplicand magnitude; div: divisor magnitude
   logic                r_neg;      // product / quotient sign
   logic                r_neg_rem;  // remainder sign (dividend sign)
   logic                r_div0;     // divisor was zero
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_result;

   logic                w_a_signed;
   logic                w_b_signed;
   logic                w_sign_a;
   logic                w_sign_b;
   logic [DATA_W-1:0]   w_mag_a;
   logic [DATA_W-1:0]   w_mag_b;
   logic                w_div0;
   logic [DATA_W-1:0]   w_early_res;
   logic [DATA_W:0]     w_trial;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W:0]     w_sum;
   logic                w_ge;
   logic [2*DATA_W-1:0] w_acc_nxt;
   logic [2*DATA_W-1:0] w_prod_fix;
   logic [DATA_W-1:0]   w_quot;
   logic [DATA_W-1:0]   w_rem;
   logic [DATA_W-1:0]   w_final;

   // Decode which operands are treated as signed for the incoming op.
   always_comb begin
      w_a_signed = 1'b0;
      w_b_signed = 1'b0;
      case (func3_i)
         3'd1:       begin w_a_signed = 1'b1; w_b_signed = 1'b1; end  // MULH
         3'd2:       begin w_a_signed = 1'b1; w_b_signed = 1'b0; end  // MULHSU
         3'd4, 3'd6: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end  // DIV, REM
         default:    begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
      endcase
   end

   assign w_sign_a    = w_a_signed & rs1_i[DATA_W-1];
   assign w_sign_b    = w_b_signed & rs2_i[DATA_W-1];
   assign w_mag_a     = f_cond_neg(rs1_i, w_sign_a);
   assign w_mag_b     = f_cond_neg(rs2_i, w_sign_b);
   assign w_div0      = func3_i[2] & (rs2_i == {DATA_W{1'b0}});
   assign w_early_res = func3_i[1] ? rs1_i : {DATA_W{1'b1}};

   // One iteration step: shift-add for multiply, restoring step for divide.
   always_comb begin
      w_trial = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
      w_diff  = w_trial - {1'b0, r_opnd};
      w_ge    = (w_trial >= {1'b0, r_opnd});
      w_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opnd};
      if (r_func3[2]) begin
         if (w_ge) w_acc_nxt = {w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
         else      w_acc_nxt = {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
      end else if (r_acc[0]) begin
         w_acc_nxt = {w_sum, r_acc[DATA_W-1:1]};
      end else begin
         w_acc_nxt = {1'b0, r_acc[2*DATA_W-1:1]};
      end
   end

   // Sign fix-up and result selection applied on the last iteration edge.
   always_comb begin
      w_prod_fix = f_cond_neg2(w_acc_nxt, r_neg);
      w_quot     = r_div0 ? {DATA_W{1'b1}} : f_cond_neg(w_acc_nxt[DATA_W-1:0], r_neg);
      w_rem      = f_cond_neg(w_acc_nxt[2*DATA_W-1:DATA_W], r_neg_rem);
      case (r_func3)
         3'd0:             w_final = w_prod_fix[DATA_W-1:0];
         3'd1, 3'd2, 3'd3: w_final = w_prod_fix[2*DATA_W-1:DATA_W];
         3'd4, 3'd5:       w_final = w_quot;
         3'd6, 3'd7:       w_final = w_rem;
         default:          w_final = {DATA_W{1'b0}};
      endcase
   end

   // Control FSM and datapath registers; reset beats flush, flush beats start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_func3   <= 3'd0;
         r_acc     <= {(2*DATA_W){1'b0}};
         r_opnd    <= {DATA_W{1'b0}};
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_cnt     <= {CNT_W{1'b0}};
         r_result  <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i && !flush_i) begin
                  r_func3   <= func3_i;
                  r_neg     <= w_sign_a ^ w_sign_b;
                  r_neg_rem <= w_sign_a;
                  r_div0    <= w_div0;
                  r_cnt     <= CNT_LOAD;
                  r_acc     <= {{DATA_W{1'b0}}, (func3_i[2] ? w_mag_a : w_mag_b)};
                  r_opnd    <= func3_i[2] ? w_mag_b : w_mag_a;
                  if (EARLY_DIV0 && w_div0) begin
                     r_result <= w_early_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_RUN;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_LAST) begin
                     r_result <= w_final;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_RUN;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o   = (r_state == S_RUN);
   assign done_o   = (r_state == S_DONE) & ~flush_i;
   assign result_o = r_result;
   assign stall_o  = start_i & ~done_o & ~flush_i;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage; consumes operands and func3 from the ID/EX pipeline register outputs.
- Result is muxed into the ALU result path feeding EX/MEM.
- While an M-extension op is in progress it asserts stall_o, which freezes PC, IF/ID and ID/EX and inserts a bubble into EX/MEM.
- One operation at a time; operands are latched at accept.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W.
EARLY_DIV0, 1, when 1 a divide by zero completes in 1 cycle; when 0 it runs the full iteration count and produces the same result.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
start_i  input  1  EX holds a valid M-extension op (opcode OP, funct7=0000001), from ID/EX.
func3_i  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
rs1_i  input  DATA_W  operand A (readData1 after forwarding).
rs2_i  input  DATA_W  operand B (readData2 after forwarding).
flush_i  input  1  abort the current op (branch/jump flush of EX).
busy_o  output  1  high in RUN state.
done_o  output  1  one-cycle pulse; result_o valid.
result_o  output  DATA_W  registered result; holds its value until the next completion.
stall_o  output  1  combinational: start_i & ~done_o & ~flush_i.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy_o=0, done_o=0, result_o=0.
  - All internal registers are cleared, including mid-operation; the op is dropped.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i & ~flush_i: latch func3, operand magnitudes and sign-fix flags; load counter=DATA_W; go to RUN.
  - Exception: with EARLY_DIV0=1, a div-class op (func3[2]=1) with rs2_i==0 goes straight to DONE with its result loaded.
- RUN:
  - Each cycle performs one iteration and decrements the counter.
  - Multiply: shift-add on a 2*DATA_W product of magnitudes.
  - Divide: restoring, one quotient bit per cycle on magnitudes.
  - When counter reaches 1, that edge applies the final sign fix, loads result_o and goes to DONE.
- DONE: done_o=1 for exactly one cycle; next state is IDLE unconditionally.
  - start_i during DONE belongs to the op just completed and is never re-accepted.
  - The new ID/EX contents are evaluated in IDLE on the following cycle.
- Latency: accept at edge T; done_o is high during cycle T+DATA_W+1, i.e. 33 cycles for DATA_W=32.
  - Divide by zero with EARLY_DIV0=1: done_o high during cycle T+1.
- stall_o is high from the cycle start_i is first seen up to, but excluding, the done_o cycle. The pipeline advances on the done_o cycle's edge.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
  - Product sign = XOR of the effective operand signs.
  - Quotient sign = sA^sB; remainder takes the sign of the dividend.
- Result select: MUL returns the low DATA_W bits; MULH/MULHSU/MULHU return the high DATA_W bits.
- Corner cases (RISC-V defined, no trap):
  - x/0: quotient = all ones; remainder = rs1.
  - Signed overflow (-2^(DATA_W-1) / -1): quotient = 0x80000000; remainder = 0.
- flush_i:
  - In RUN or DONE: next state IDLE, done_o forced low that cycle, result_o unchanged.
  - In IDLE: blocks accept.
- rst has priority over flush_i, and flush_i has priority over start_i.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall_o high 33 cycles; done_o at T+33; result_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- REM same operands -> 0xFFFFFFFF.
- DIVU 0x64 / 7 -> 0x0E; REMU same operands -> 0x02.
- DIVU 0x1234 / 0 -> done_o at T+1, result 0xFFFFFFFF.
- REM 0x1234 % 0 -> 0x1234.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM same operands -> 0.
- Back-to-back: two MULs with start_i held, ID/EX advancing on the done_o cycle -> exactly two done_o pulses, 34 cycles apart, with correct results.
- flush_i pulsed at T+10 -> busy_o=0 at T+11; no done_o; result_o keeps its prior value.
- rst pulsed at T+5 -> IDLE and all outputs 0 at the next edge.
- After that flush or reset, a new MUL is accepted and completes normally.
